plic_claim_arbiter: RTL

- Single-target PLIC core for the APB4 PLIC.
- Latches gateway requests into pending bits and selects the highest-priority enabled pending source above threshold through a registered arbitration stage.
- Drives the external interrupt line and sequences the claim/complete protocol back to the per-source gateways.
- Sits between the gateway array and the APB register file; the register file supplies priority, enable and threshold, and converts CLAIMCOMP reads and writes into pulses.

---
 rtl/plic_claim_arbiter_if.sv | 24 ++
 rtl/plic_claim_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/plic_claim_arbiter_if.sv
// Gateway handshake and claim/complete bus shared by the PLIC core and its neighbours.
// The master side is the gateway array plus register file; the slave side is the core.
interface plic_claim_arbiter_if #(
    parameter int IRQ_NUM  = 3,
    parameter int ID_WIDTH = $clog2(IRQ_NUM)
);
    logic [IRQ_NUM-1:0]  gw_valid_i;
    logic [IRQ_NUM-1:0]  gw_ready_o;
    logic [IRQ_NUM-1:0]  gw_comp_o;
    logic                claim_i;
    logic [ID_WIDTH-1:0] claim_id_o;
    logic                comp_i;
    logic [ID_WIDTH-1:0] comp_id_i;

    modport master (
        output gw_valid_i, claim_i, comp_i, comp_id_i,
        input  gw_ready_o, gw_comp_o, claim_id_o
    );

    modport slave (
        input  gw_valid_i, claim_i, comp_i, comp_id_i,
        output gw_ready_o, gw_comp_o, claim_id_o
    );
endinterface

// File: rtl/plic_claim_arbiter.sv
// Single-target PLIC core: pending latch, registered priority arbitration, claim/complete.
// Optional sticky completion error flag enabled by defining PLIC_COMP_ERR_EN.
module plic_claim_arbiter #(
    parameter int IRQ_NUM        = 3,
    parameter int IRQ_PRIO_WIDTH = 3,
    parameter int ID_WIDTH       = $clog2(IRQ_NUM)
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    plic_claim_arbiter_if.slave               cc_if,
    input  logic [IRQ_NUM*IRQ_PRIO_WIDTH-1:0] prio_i,
    input  logic [IRQ_NUM-1:0]                ie_i,
    input  logic [IRQ_PRIO_WIDTH-1:0]         thold_i,
    output logic [IRQ_NUM-1:0]                ip_o,
    output logic                              ext_irq_o,
    output logic                              err_o
);
    logic [IRQ_NUM-1:0]        r_ip;
    logic [IRQ_NUM-1:0]        r_claimed;
    logic [IRQ_NUM-1:0]        r_gw_comp;
    logic [ID_WIDTH-1:0]       r_max_id_p1;
    logic [IRQ_PRIO_WIDTH-1:0] r_max_prio_p1;

    logic [IRQ_PRIO_WIDTH-1:0] w_prio [IRQ_NUM];
    logic [ID_WIDTH-1:0]       w_best_id;
    logic [IRQ_PRIO_WIDTH-1:0] w_best_prio;
    logic                      w_claim_ok;
    logic [ID_WIDTH-1:0]       w_claim_id;
    logic [IRQ_NUM-1:0]        w_ready;
    logic [IRQ_NUM-1:0]        w_hs;
    logic [IRQ_NUM-1:0]        w_claim_oh;
    logic [IRQ_NUM-1:0]        w_comp_oh;
    logic [IRQ_NUM-1:0]        w_ip_nxt;
    logic [IRQ_NUM-1:0]        w_claimed_nxt;

    always_comb begin
        for (int i = 0; i < IRQ_NUM; i++) begin
            w_prio[i] = prio_i[i*IRQ_PRIO_WIDTH +: IRQ_PRIO_WIDTH];
        end
    end

    // Ascending scan with strict '>' keeps the lowest ID on a priority tie.
    always_comb begin
        w_best_id   = '0;
        w_best_prio = '0;
        for (int i = 1; i < IRQ_NUM; i++) begin
            if (r_ip[i] && ie_i[i] && (w_prio[i] != '0) && (w_prio[i] > w_best_prio)) begin
                w_best_id   = ID_WIDTH'(i);
                w_best_prio = w_prio[i];
            end
        end
    end

    // Revalidate the registered winner against live state so a claim issued
    // before the arbitration stage catches up never hands out a stale ID.
    always_comb begin
        w_claim_ok = r_ip[r_max_id_p1] && ie_i[r_max_id_p1] &&
                     (w_prio[r_max_id_p1] > thold_i);
        w_claim_id = w_claim_ok ? r_max_id_p1 : '0;
    end

    always_comb begin
        w_ready    = ~r_ip & ~r_claimed;
        w_ready[0] = 1'b0;
        w_hs       = cc_if.gw_valid_i & w_ready;
        w_claim_oh = '0;
        w_comp_oh  = '0;
        for (int i = 1; i < IRQ_NUM; i++) begin
            w_claim_oh[i] = cc_if.claim_i && (w_claim_id == ID_WIDTH'(i));
            w_comp_oh[i]  = cc_if.comp_i && (cc_if.comp_id_i == ID_WIDTH'(i)) && r_claimed[i];
        end
        w_ip_nxt      = (r_ip | w_hs) & ~w_claim_oh;
        w_claimed_nxt = (r_claimed | w_claim_oh) & ~w_comp_oh;
    end

    // Stage p1: pending/claimed state and arbitration result
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ip          <= '0;
            r_claimed     <= '0;
            r_gw_comp     <= '0;
            r_max_id_p1   <= '0;
            r_max_prio_p1 <= '0;
        end else begin
            r_ip          <= w_ip_nxt;
            r_claimed     <= w_claimed_nxt;
            r_gw_comp     <= w_comp_oh;
            r_max_id_p1   <= w_best_id;
            r_max_prio_p1 <= w_best_prio;
        end
    end

`ifdef PLIC_COMP_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else if (cc_if.comp_i && (w_comp_oh == '0)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign cc_if.gw_ready_o = w_ready;
    assign cc_if.gw_comp_o  = r_gw_comp;
    assign cc_if.claim_id_o = w_claim_id;
    assign ip_o             = r_ip;
    assign ext_irq_o        = (r_max_prio_p1 > thold_i);
endmodule
